circular_stack_ckpt: RTL and testbench
======================================

Name: circular_stack_ckpt

Overview:
- Parametrised circular LIFO (return-address-stack style) with an overwrite-oldest policy on overflow.
- Adds three things to the basic circular stack: one speculative checkpoint/restore slot, a second-entry peek port, and an explicit full flag.
- Adds overflow/underflow status outputs.
- Sits in the fetch/predict stage. Push on call, pop on return, checkpoint on branch prediction, restore on misprediction.

Parameters:
- SIZE, 8, number of entries; power of two, >= 2
- WIDTH, 32, entry data width
- CLEAR_EMPTY, 1, when 1 the data outputs are driven to zero while invalid; when 0 they show raw storage

Ports:
- s_clk_i  input  1  clock
- s_reset_i  input  1  synchronous active-high reset
- s_flush_i  input  1  empty the stack and invalidate the checkpoint
- s_push_i  input  1  push s_data_i
- s_pop_i  input  1  pop top entry
- s_data_i  input  WIDTH  data to push
- s_ckpt_i  input  1  save the post-operation pointer/count state
- s_restore_i  input  1  restore the saved pointer/count state
- s_empty_o  output  1  count == 0
- s_full_o  output  1  count == SIZE
- s_count_o  output  PTRW+1  current entry count
- s_data_o  output  WIDTH  top entry
- s_data1_o  output  WIDTH  entry below top
- s_ovf_o  output  1  sticky: an entry was overwritten
- s_udf_o  output  1  combinational pulse: pop on empty
- s_ckpt_vld_o  output  1  checkpoint slot holds valid state

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Clock port is s_clk_i; reset port is s_reset_i.
- Widths:
  - PTRW = $clog2(SIZE).
  - top pointer is PTRW bits and wraps modulo SIZE.
  - count is PTRW+1 bits and saturates at SIZE.
- Reset values: top=0, count=0, ckpt_top=0, ckpt_cnt=0, ckpt_vld=0, ovf=0.
  - Outputs after reset: empty=1, full=0, count=0, ovf=0, ckpt_vld=0.
  - With CLEAR_EMPTY=1: data_o=0, data1_o=0.
  - Storage is not reset.
- Priority per cycle: reset > flush > restore > push/pop.
- Flush: top=0, count=0, ckpt_vld=0, ovf=0. Push, pop, ckpt and restore are ignored that cycle.
- Restore:
  - Applies only when ckpt_vld=1: top=ckpt_top, count=ckpt_cnt.
  - Push/pop are ignored that cycle.
  - Restore with ckpt_vld=0 is a no-op, and push/pop proceed normally.
  - Storage contents are not restored; entries overwritten since the checkpoint stay overwritten.
- Push only:
  - Write at top+1; top=top+1.
  - count=count+1 when not full; when full, count stays SIZE, the oldest entry is overwritten and ovf is set (sticky).
- Pop only, not empty: top=top-1, count=count-1.
- Pop only, empty: no state change. s_udf_o=1 in the same cycle.
- Push and pop together:
  - Not empty: write at top (replace), top and count unchanged, no ovf.
  - Empty: acts as a push only (count=1, data at top+1). s_udf_o=0.
- Checkpoint:
  - s_ckpt_i latches the next-state top/count of the same cycle (after push/pop or restore) and sets ckpt_vld=1.
  - Ignored under flush.
  - Ckpt together with restore saves the restored state.
- Read latency:
  - Storage writes become visible on s_data_o the next cycle.
  - Outputs are combinational from the registered top/count. No same-cycle bypass of s_data_i.
- s_data_o = mem[top] when count >= 1; s_data1_o = mem[top-1] (mod SIZE) when count >= 2. Otherwise the output is zero with CLEAR_EMPTY=1.
- s_udf_o is gated by flush, reset and a valid restore.

Decomposition:
- Package cstack_pkg holds:
  - function cstack_ptrw(SIZE), which returns $clog2(SIZE)
  - a packed struct cstack_state_t {top, count}, shared by the live state and the checkpoint register
- Sub-module circular_stack_regfile: SIZE x WIDTH flip-flop array with one write port and two read ports (top, top-1).
- Control, pointer arithmetic and checkpoint logic stay in circular_stack_ckpt.
- Add a SIZE power-of-two assertion.

Test Plan:
- Reset, then push 0xA1, 0xA2, 0xA3 -> count=3, data_o=0xA3, data1_o=0xA2. Pop -> data_o=0xA2, count=2.
- SIZE=8: push 10 values 1..10 -> count=8, full=1, ovf=1. Then 8 pops return 10 down to 3, then empty=1.
- Pop on empty -> s_udf_o=1 that cycle, count stays 0. Push+pop on empty with 0x55 -> count=1, data_o=0x55.
- Push 0x11, 0x22, then push+pop with 0x33 -> count=2, data_o=0x33, data1_o=0x11.
- Push 0x11 with ckpt, then push 0x22, 0x33, pop, then restore -> count=1, data_o=0x11, ckpt_vld stays 1. Restore+push in the same cycle -> push ignored.
- Ckpt, then flush -> ckpt_vld=0, and a following restore is a no-op. Assert s_reset_i mid-sequence (count=5) -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/circular_stack_ckpt_pkg.sv
// Shared types and helpers for the circular return-address stack.
package cstack_pkg;

    // Widest pointer the shared state struct can carry (SIZE up to 256).
    localparam int unsigned CSTACK_PTRW_MAX = 8;

    typedef logic [CSTACK_PTRW_MAX-1:0] cstack_ptr_t;
    typedef logic [CSTACK_PTRW_MAX:0]   cstack_cnt_t;

    // Pointer/count pair used by both the live stack and the checkpoint slot.
    typedef struct packed {
        cstack_ptr_t top;
        cstack_cnt_t count;
    } cstack_state_t;

    // Pointer width for a given stack depth.
    function automatic int unsigned cstack_ptrw(input int unsigned size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/circular_stack_ckpt_if.sv
// Control and data bundle between the fetch/predict logic and the stack.
interface circular_stack_ckpt_if #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned PTRW = cstack_pkg::cstack_ptrw(SIZE);

    logic             s_flush_i;
    logic             s_push_i;
    logic             s_pop_i;
    logic [WIDTH-1:0] s_data_i;
    logic             s_ckpt_i;
    logic             s_restore_i;
    logic             s_empty_o;
    logic             s_full_o;
    logic [PTRW:0]    s_count_o;
    logic [WIDTH-1:0] s_data_o;
    logic [WIDTH-1:0] s_data1_o;
    logic             s_ovf_o;
    logic             s_udf_o;
    logic             s_ckpt_vld_o;

    modport master (
        output s_flush_i, s_push_i, s_pop_i, s_data_i, s_ckpt_i, s_restore_i,
        input  s_empty_o, s_full_o, s_count_o, s_data_o, s_data1_o,
               s_ovf_o, s_udf_o, s_ckpt_vld_o
    );

    modport slave (
        input  s_flush_i, s_push_i, s_pop_i, s_data_i, s_ckpt_i, s_restore_i,
        output s_empty_o, s_full_o, s_count_o, s_data_o, s_data1_o,
               s_ovf_o, s_udf_o, s_ckpt_vld_o
    );

endinterface

// File: rtl/circular_stack_ckpt_regfile.sv
// Flip-flop storage for the stack: one write port, two async read ports.
module circular_stack_regfile #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTRW  = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTRW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTRW-1:0]  raddr0,
    input  logic [PTRW-1:0]  raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [SIZE];

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/circular_stack_ckpt.sv
// Circular LIFO with overwrite-oldest, one checkpoint slot and a second-entry peek.
module circular_stack_ckpt
    import cstack_pkg::*;
#(
    parameter int unsigned SIZE        = 8,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CLEAR_EMPTY = 1
) (
    input  logic                 s_clk_i,
    input  logic                 s_reset_i,
    circular_stack_ckpt_if.slave cs
);

    localparam int unsigned PTRW     = cstack_ptrw(SIZE);
    localparam cstack_ptr_t PTR_MASK = cstack_ptr_t'(SIZE - 1);
    localparam cstack_cnt_t CNT_FULL = cstack_cnt_t'(SIZE);

    // Depth must be a power of two that fits the shared state struct.
    if ((SIZE < 2) || ((SIZE & (SIZE - 1)) != 0) || (SIZE > (1 << CSTACK_PTRW_MAX))) begin : g_size_check
        $error("circular_stack_ckpt: SIZE must be a power of two in 2..%0d", 1 << CSTACK_PTRW_MAX);
    end

    cstack_state_t    st_q, st_d;
    cstack_state_t    ckpt_q, ckpt_d;
    logic             ckpt_vld_q, ckpt_vld_d;
    logic             ovf_q, ovf_d;
    logic             we_c;
    cstack_ptr_t      waddr_c;
    logic             udf_c;
    logic             empty_c;
    logic             full_c;
    cstack_ptr_t      top_inc_c;
    cstack_ptr_t      top_dec_c;
    logic [WIDTH-1:0] rd0_c;
    logic [WIDTH-1:0] rd1_c;

    assign empty_c   = (st_q.count == '0);
    assign full_c    = (st_q.count == CNT_FULL);
    assign top_inc_c = (st_q.top + cstack_ptr_t'(1)) & PTR_MASK;
    assign top_dec_c = (st_q.top - cstack_ptr_t'(1)) & PTR_MASK;

    // Next-state: flush > restore > push/pop, then optional checkpoint of the result.
    always_comb begin
        st_d       = st_q;
        ckpt_d     = ckpt_q;
        ckpt_vld_d = ckpt_vld_q;
        ovf_d      = ovf_q;
        we_c       = 1'b0;
        waddr_c    = st_q.top;
        udf_c      = 1'b0;

        if (cs.s_flush_i) begin
            st_d       = '0;
            ckpt_vld_d = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            if (cs.s_restore_i && ckpt_vld_q) begin
                st_d = ckpt_q;
            end else if (cs.s_push_i && (!cs.s_pop_i || empty_c)) begin
                we_c     = 1'b1;
                waddr_c  = top_inc_c;
                st_d.top = top_inc_c;
                if (full_c) begin
                    ovf_d = 1'b1;
                end else begin
                    st_d.count = st_q.count + cstack_cnt_t'(1);
                end
            end else if (cs.s_push_i && cs.s_pop_i) begin
                we_c = 1'b1;
            end else if (cs.s_pop_i) begin
                if (empty_c) begin
                    udf_c = 1'b1;
                end else begin
                    st_d.top   = top_dec_c;
                    st_d.count = st_q.count - cstack_cnt_t'(1);
                end
            end

            if (cs.s_ckpt_i) begin
                ckpt_d     = st_d;
                ckpt_vld_d = 1'b1;
            end
        end

        if (s_reset_i) begin
            we_c  = 1'b0;
            udf_c = 1'b0;
        end
    end

    // State, checkpoint and sticky overflow registers.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            st_q       <= '0;
            ckpt_q     <= '0;
            ckpt_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            ckpt_q     <= ckpt_d;
            ckpt_vld_q <= ckpt_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    circular_stack_regfile #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH),
        .PTRW  (PTRW)
    ) u_regfile (
        .clk    (s_clk_i),
        .we     (we_c),
        .waddr  (waddr_c[PTRW-1:0]),
        .wdata  (cs.s_data_i),
        .raddr0 (st_q.top[PTRW-1:0]),
        .raddr1 (top_dec_c[PTRW-1:0]),
        .rdata0 (rd0_c),
        .rdata1 (rd1_c)
    );

    // Status and peek outputs decoded from the registered pointer/count.
    always_comb begin
        cs.s_empty_o    = empty_c;
        cs.s_full_o     = full_c;
        cs.s_count_o    = st_q.count[PTRW:0];
        cs.s_ovf_o      = ovf_q;
        cs.s_udf_o      = udf_c;
        cs.s_ckpt_vld_o = ckpt_vld_q;
        cs.s_data_o     = rd0_c;
        cs.s_data1_o    = rd1_c;
        if ((CLEAR_EMPTY != 0) && empty_c) begin
            cs.s_data_o = '0;
        end
        if ((CLEAR_EMPTY != 0) && (st_q.count < cstack_cnt_t'(2))) begin
            cs.s_data1_o = '0;
        end
    end

endmodule

// File: tb/tb_circular_stack_ckpt.sv
// Table-driven bench for circular_stack_ckpt (SIZE=8, WIDTH=32, CLEAR_EMPTY=1).
module tb_circular_stack_ckpt;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        bit          rst, flush, push, pop, ckpt, restore;
        logic [31:0] data;
        int          cnt;
        logic [31:0] d0, d1;
        bit          empty, full, ovf, cvld, udf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    circular_stack_ckpt_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    circular_stack_ckpt #(.SIZE(SIZE), .WIDTH(WIDTH), .CLEAR_EMPTY(1)) dut (
        .s_clk_i   (clk),
        .s_reset_i (rst),
        .cs        (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit f, bit pu, bit po, bit ck, bit rs, logic [31:0] d,
                                int cnt, logic [31:0] d0, logic [31:0] d1, bit ovf, bit cvld, bit udf);
        vec_t v;
        v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.ckpt = ck; v.restore = rs; v.data = d;
        v.cnt = cnt; v.d0 = d0; v.d1 = d1; v.ovf = ovf; v.cvld = cvld; v.udf = udf;
        v.empty = (cnt == 0);
        v.full  = (cnt == int'(SIZE));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector, check the same-cycle underflow pulse, then the registered state.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst              = v.rst;
        bus.s_flush_i    = v.flush;
        bus.s_push_i     = v.push;
        bus.s_pop_i      = v.pop;
        bus.s_ckpt_i     = v.ckpt;
        bus.s_restore_i  = v.restore;
        bus.s_data_i     = v.data;
        #1;
        chk($sformatf("v%0d udf", idx), 32'(bus.s_udf_o), 32'(v.udf));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d count", idx), 32'(bus.s_count_o), 32'(e.cnt));
        chk($sformatf("v%0d data", idx), bus.s_data_o, e.d0);
        chk($sformatf("v%0d data1", idx), bus.s_data1_o, e.d1);
        chk($sformatf("v%0d empty", idx), 32'(bus.s_empty_o), 32'(e.empty));
        chk($sformatf("v%0d full", idx), 32'(bus.s_full_o), 32'(e.full));
        chk($sformatf("v%0d ovf", idx), 32'(bus.s_ovf_o), 32'(e.ovf));
        chk($sformatf("v%0d ckpt_vld", idx), 32'(bus.s_ckpt_vld_o), 32'(e.cvld));
    endtask

    initial begin
        int n;
        bus.s_flush_i = 1'b0; bus.s_push_i = 1'b0; bus.s_pop_i = 1'b0;
        bus.s_ckpt_i = 1'b0; bus.s_restore_i = 1'b0; bus.s_data_i = '0;

        //              r f pu po ck rs data    cnt d0     d1     ovf cv udf
        tbl.push_back(mk(1,0,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'hA1,   1, 'hA1,  0,     0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'hA2,   2, 'hA2,  'hA1,  0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'hA3,   3, 'hA3,  'hA2,  0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0, 0,      2, 'hA2,  'hA1,  0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        // Overflow: ten pushes into eight slots keep the newest eight.
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(0,0,1,0,0,0, 32'(i), (i > 8) ? 8 : i, 32'(i),
                             (i >= 2) ? 32'(i - 1) : 0, (i >= 9), 0, 0));
        for (int k = 0; k < 8; k++) begin
            n = 7 - k;
            tbl.push_back(mk(0,0,0,1,0,0, 0, n, (n >= 1) ? 32'(9 - k) : 0,
                             (n >= 2) ? 32'(8 - k) : 0, 1, 0, 0));
        end
        tbl.push_back(mk(0,0,0,1,0,0, 0,      0, 0,     0,     1,0,1));
        tbl.push_back(mk(0,0,1,1,0,0, 'h55,   1, 'h55,  0,     1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        // Push+pop replaces the top in place.
        tbl.push_back(mk(0,0,1,0,0,0, 'h11,   1, 'h11,  0,     0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'h22,   2, 'h22,  'h11,  0,0,0));
        tbl.push_back(mk(0,0,1,1,0,0, 'h33,   2, 'h33,  'h11,  0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        // Checkpoint / restore.
        tbl.push_back(mk(0,0,1,0,1,0, 'h11,   1, 'h11,  0,     0,1,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'h22,   2, 'h22,  'h11,  0,1,0));
        tbl.push_back(mk(0,0,1,0,0,0, 'h33,   3, 'h33,  'h22,  0,1,0));
        tbl.push_back(mk(0,0,0,1,0,0, 0,      2, 'h22,  'h11,  0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,      1, 'h11,  0,     0,1,0));
        tbl.push_back(mk(0,0,1,0,0,1, 'h77,   1, 'h11,  0,     0,1,0));
        tbl.push_back(mk(0,0,0,0,1,0, 0,      1, 'h11,  0,     0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,      0, 0,     0,     0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1, 'h66,   1, 'h66,  0,     0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 0,      0, 0,     0,     0,0,0));
        tbl.push_back(mk(0,1,0,1,0,0, 0,      0, 0,     0,     0,0,0));
        // Reset mid-sequence with five entries.
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,0,1,0,0,0, 32'(i), i, 32'(i), (i >= 2) ? 32'(i - 1) : 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0,1,0, 0,      5, 5,     4,     0,1,0));
        tbl.push_back(mk(1,0,1,0,0,0, 'h99,   0, 0,     0,     0,0,0));
        tbl.push_back(mk(1,0,0,1,0,0, 0,      0, 0,     0,     0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Hand sequence: restore keeps overwritten data; ckpt+restore saves the restored state.
        apply(mk(0,0,1,0,0,0, 1,     1, 1, 0, 0,0,0), 100);
        apply(mk(0,0,1,0,1,0, 2,     2, 2, 1, 0,1,0), 101);
        apply(mk(0,0,0,1,0,0, 0,     1, 1, 0, 0,1,0), 102);
        apply(mk(0,0,1,0,0,0, 9,     2, 9, 1, 0,1,0), 103);
        apply(mk(0,0,0,1,0,0, 0,     1, 1, 0, 0,1,0), 104);
        apply(mk(0,0,0,1,1,1, 0,     2, 9, 1, 0,1,0), 105);
        apply(mk(0,0,0,1,0,0, 0,     1, 1, 0, 0,1,0), 106);
        apply(mk(0,0,0,0,0,1, 0,     2, 9, 1, 0,1,0), 107);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
